// File: rtl/video_request_scheduler_pkg.sv
// Shared widths and FSM encoding for the video request scheduler.
package video_request_scheduler_pkg;

    localparam int HACTIVE_BITS   = 11;
    localparam int VACTIVE_BITS   = 11;
    localparam int CHUNKNUM_BITS  = 6;
    localparam int REQUEST_BITS   = VACTIVE_BITS + CHUNKNUM_BITS;
    localparam int BITS_PER_PIXEL = 16;
    localparam int PIXELS_BITS    = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_POP    = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_STREAM = 3'd4
    } state_t;

endpackage

// File: rtl/video_request_scheduler_if.sv
// Request FIFO, upstream request, pixel input and response FIFO signals.
interface video_request_scheduler_if;
    import video_request_scheduler_pkg::*;

    logic                      request_fifo_empty;
    logic                      request_fifo_read_enable;
    logic [REQUEST_BITS-1:0]   request_fifo_read_data;

    logic                      up_request_valid;
    logic                      up_request_ready;
    logic [VACTIVE_BITS-1:0]   up_request_line;
    logic [CHUNKNUM_BITS-1:0]  up_request_chunk;
    logic [PIXELS_BITS-1:0]    up_request_pixels;

    logic                      pixel_in_valid;
    logic                      pixel_in_ready;
    logic [BITS_PER_PIXEL-1:0] pixel_in_data;

    logic                      response_fifo_full;
    logic                      response_fifo_write_enable;
    logic [BITS_PER_PIXEL-1:0] response_fifo_write_data;

    // master is the scheduler, slave is the surrounding FIFOs/upstream
    modport master (
        input  request_fifo_empty, request_fifo_read_data,
        output request_fifo_read_enable,
        output up_request_valid, up_request_line, up_request_chunk, up_request_pixels,
        input  up_request_ready,
        input  pixel_in_valid, pixel_in_data,
        output pixel_in_ready,
        input  response_fifo_full,
        output response_fifo_write_enable, response_fifo_write_data
    );

    modport slave (
        output request_fifo_empty, request_fifo_read_data,
        input  request_fifo_read_enable,
        input  up_request_valid, up_request_line, up_request_chunk, up_request_pixels,
        output up_request_ready,
        output pixel_in_valid, pixel_in_data,
        input  pixel_in_ready,
        output response_fifo_full,
        input  response_fifo_write_enable, response_fifo_write_data
    );

endinterface

// File: rtl/video_request_scheduler_decoder.sv
// Maps a chunk index and the active line width to a pixel count, flagging chunks past the line end.
module video_request_scheduler_decoder
    import video_request_scheduler_pkg::*;
#(
    parameter int CHUNK_BITS = 5
) (
    input  logic [CHUNKNUM_BITS-1:0] chunk,
    input  logic [HACTIVE_BITS-1:0]  h_active,
    output logic [PIXELS_BITS-1:0]   count,
    output logic                     invalid
);

    logic [HACTIVE_BITS-1:0] full_chunks;
    logic [HACTIVE_BITS-1:0] chunk_ext;
    logic [PIXELS_BITS-1:0]  rem_pixels;

    assign full_chunks = h_active >> CHUNK_BITS;
    assign chunk_ext   = HACTIVE_BITS'(chunk);
    assign rem_pixels  = PIXELS_BITS'(h_active[CHUNK_BITS-1:0]);

    always_comb begin
        count   = '0;
        invalid = 1'b0;
        if (chunk_ext < full_chunks) begin
            count = PIXELS_BITS'(1) << CHUNK_BITS;
        end else if ((chunk_ext == full_chunks) && (rem_pixels != '0)) begin
            count = rem_pixels;
        end else begin
            invalid = 1'b1;
        end
    end

endmodule

// File: rtl/video_request_scheduler.sv
// Pops line/chunk requests, issues them upstream one at a time and streams the returned pixels
// into the response FIFO, with a no-progress watchdog and sticky error flags.
//
// state     | meaning
// ST_IDLE   | waiting for enable and a queued request; drains stray pixels
// ST_POP    | FIFO read data valid, capture line/chunk
// ST_DECODE | size the chunk from h_active, drop if past line end
// ST_ISSUE  | upstream request held until ready
// ST_STREAM | forward pixels until count reaches zero or watchdog expires
module video_request_scheduler
    import video_request_scheduler_pkg::*;
#(
    parameter int CHUNK_BITS   = 5,
    parameter int TIMEOUT_BITS = 10
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [HACTIVE_BITS-1:0]   h_active,
    input  logic                      clear_errors,
    video_request_scheduler_if.master bus,
    output logic                      busy,
    output logic                      timeout_error,
    output logic                      overflow_error,
    output logic                      bad_request_error
);

    localparam logic [TIMEOUT_BITS-1:0] WATCHDOG_LIMIT = '1;

    state_t                   state;
    logic [VACTIVE_BITS-1:0]  line_q;
    logic [CHUNKNUM_BITS-1:0] chunk_q;
    logic [PIXELS_BITS-1:0]   remaining;
    logic [TIMEOUT_BITS-1:0]  watchdog;
    logic [PIXELS_BITS-1:0]   decoded_count;
    logic                     decoded_invalid;
    logic                     streaming;
    logic                     pixel_accept;
    logic                     timeout_event;
    logic                     overflow_event;
    logic                     bad_event;

    video_request_scheduler_decoder #(
        .CHUNK_BITS (CHUNK_BITS)
    ) u_decoder (
        .chunk    (chunk_q),
        .h_active (h_active),
        .count    (decoded_count),
        .invalid  (decoded_invalid)
    );

    assign streaming = (state == ST_STREAM);
    assign busy      = (state != ST_IDLE);

    // Gated by reset so a request is never lost to a pop during the reset cycle.
    assign bus.request_fifo_read_enable = reset_n && (state == ST_IDLE) && enable
                                          && !bus.request_fifo_empty;

    assign bus.pixel_in_ready             = !streaming || !bus.response_fifo_full;
    assign pixel_accept                   = reset_n && streaming && bus.pixel_in_valid
                                            && !bus.response_fifo_full;
    assign bus.response_fifo_write_enable = pixel_accept;
    assign bus.response_fifo_write_data   = bus.pixel_in_data;

    // Watchdog counts down idle stream cycles; terminal count of one means the limit is reached.
    assign timeout_event  = streaming && !pixel_accept && (watchdog == TIMEOUT_BITS'(1));
    assign overflow_event = !streaming && bus.pixel_in_valid;
    assign bad_event      = (state == ST_DECODE) && decoded_invalid;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                 <= ST_IDLE;
            line_q                <= '0;
            chunk_q               <= '0;
            remaining             <= '0;
            watchdog              <= '0;
            bus.up_request_valid  <= 1'b0;
            bus.up_request_line   <= '0;
            bus.up_request_chunk  <= '0;
            bus.up_request_pixels <= '0;
            timeout_error         <= 1'b0;
            overflow_error        <= 1'b0;
            bad_request_error     <= 1'b0;
        end else begin
            timeout_error     <= (timeout_error && !clear_errors) || timeout_event;
            overflow_error    <= (overflow_error && !clear_errors) || overflow_event;
            bad_request_error <= (bad_request_error && !clear_errors) || bad_event;

            case (state)
                ST_IDLE: begin
                    if (bus.request_fifo_read_enable) begin
                        state <= ST_POP;
                    end
                end
                ST_POP: begin
                    line_q  <= bus.request_fifo_read_data[REQUEST_BITS-1:CHUNKNUM_BITS];
                    chunk_q <= bus.request_fifo_read_data[CHUNKNUM_BITS-1:0];
                    state   <= ST_DECODE;
                end
                ST_DECODE: begin
                    if (decoded_invalid) begin
                        state <= ST_IDLE;
                    end else begin
                        bus.up_request_valid  <= 1'b1;
                        bus.up_request_line   <= line_q;
                        bus.up_request_chunk  <= chunk_q;
                        bus.up_request_pixels <= decoded_count;
                        state                 <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (bus.up_request_ready) begin
                        bus.up_request_valid <= 1'b0;
                        remaining            <= bus.up_request_pixels;
                        watchdog             <= WATCHDOG_LIMIT;
                        state                <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (pixel_accept) begin
                        remaining <= remaining - PIXELS_BITS'(1);
                        watchdog  <= WATCHDOG_LIMIT;
                        if (remaining == PIXELS_BITS'(1)) begin
                            state <= ST_IDLE;
                        end
                    end else if (timeout_event) begin
                        state <= ST_IDLE;
                    end else begin
                        watchdog <= watchdog - TIMEOUT_BITS'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_request_scheduler.sv
// Directed bench: table of chunk-sizing vectors plus hand sequences for stall, timeout, overflow and reset.
module tb_video_request_scheduler;
    import video_request_scheduler_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear_errors = 1'b0;
    logic [10:0] h_active = 11'd640;
    logic        busy, timeout_error, overflow_error, bad_request_error;

    int tests = 0;
    int fails = 0;

    int          wr_count = 0;
    int          hs_count = 0;
    int          data_bad = 0;
    logic [5:0]  hs_pixels = '0;
    logic [10:0] hs_line = '0;
    logic [5:0]  hs_chunk = '0;

    video_request_scheduler_if bus();

    video_request_scheduler #(
        .CHUNK_BITS   (5),
        .TIMEOUT_BITS (10)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .enable            (enable),
        .h_active          (h_active),
        .clear_errors      (clear_errors),
        .bus               (bus),
        .busy              (busy),
        .timeout_error     (timeout_error),
        .overflow_error    (overflow_error),
        .bad_request_error (bad_request_error)
    );

    always #5 clock = ~clock;

    // Observe writes and handshakes half a cycle ahead of the edge that commits them.
    always @(negedge clock) begin
        if (bus.response_fifo_write_enable) begin
            wr_count <= wr_count + 1;
            if (bus.response_fifo_write_data !== bus.pixel_in_data) data_bad <= data_bad + 1;
        end
        if (bus.up_request_valid && bus.up_request_ready) begin
            hs_count  <= hs_count + 1;
            hs_pixels <= bus.up_request_pixels;
            hs_line   <= bus.up_request_line;
            hs_chunk  <= bus.up_request_chunk;
        end
    end

    typedef struct {
        logic [10:0] h_active;
        logic [10:0] line;
        logic [5:0]  chunk;
        bit          valid;
        int          pixels;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_req(input logic [10:0] line, input logic [5:0] chunk, output bit ok);
        ok = 1'b0;
        bus.request_fifo_empty = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (bus.request_fifo_read_enable) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        bus.request_fifo_read_data = {line, chunk};
        bus.request_fifo_empty     = 1'b1;
    endtask

    task automatic wait_hs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (bus.up_request_valid && bus.up_request_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
    endtask

    task automatic send_pixels(input int n, output int accepted);
        accepted = 0;
        for (int i = 0; (i < n * 4 + 20) && (accepted < n); i++) begin
            bus.pixel_in_valid = 1'b1;
            bus.pixel_in_data  = 16'($urandom);
            @(negedge clock);
            if (bus.pixel_in_ready) accepted++;
            tick();
        end
        bus.pixel_in_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
    endtask

    task automatic run_request(input logic [10:0] line, input logic [5:0] chunk,
                               input bit exp_valid, input int exp_pixels, input string tag);
        int wr0, hs0, got;
        bit ok;
        wr0 = wr_count;
        hs0 = hs_count;
        push_req(line, chunk, ok);
        check({tag, " pop"}, int'(ok), 1);
        if (exp_valid) begin
            wait_hs(ok);
            check({tag, " handshake"}, int'(ok), 1);
            check({tag, " pixels"}, int'(hs_pixels), exp_pixels);
            check({tag, " line"}, int'(hs_line), int'(line));
            check({tag, " chunk"}, int'(hs_chunk), int'(chunk));
            send_pixels(exp_pixels, got);
            tick();
            check({tag, " writes"}, wr_count - wr0, exp_pixels);
            check({tag, " idle"}, int'(busy), 0);
        end else begin
            repeat (3) tick();
            check({tag, " bad_request"}, int'(bad_request_error), 1);
            check({tag, " no handshake"}, hs_count - hs0, 0);
            check({tag, " idle"}, int'(busy), 0);
            pulse_clear();
            check({tag, " bad cleared"}, int'(bad_request_error), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int  wr0, hs0, got;
        bit  ok;

        vecs[0]  = '{11'd640,  11'd5, 6'd0,  1'b1, 32};
        vecs[1]  = '{11'd640,  11'd5, 6'd19, 1'b1, 32};
        vecs[2]  = '{11'd640,  11'd5, 6'd20, 1'b0, 0};
        vecs[3]  = '{11'd650,  11'd7, 6'd20, 1'b1, 10};
        vecs[4]  = '{11'd650,  11'd7, 6'd21, 1'b0, 0};
        vecs[5]  = '{11'd31,   11'd1, 6'd0,  1'b1, 31};
        vecs[6]  = '{11'd32,   11'd2, 6'd0,  1'b1, 32};
        vecs[7]  = '{11'd32,   11'd2, 6'd1,  1'b0, 0};
        vecs[8]  = '{11'd2047, 11'd3, 6'd63, 1'b1, 31};
        vecs[9]  = '{11'd2047, 11'd3, 6'd62, 1'b1, 32};
        vecs[10] = '{11'd1,    11'd0, 6'd0,  1'b1, 1};
        vecs[11] = '{11'd0,    11'd4, 6'd0,  1'b0, 0};

        bus.request_fifo_empty     = 1'b0;
        bus.request_fifo_read_data = '0;
        bus.up_request_ready       = 1'b0;
        bus.pixel_in_valid         = 1'b0;
        bus.pixel_in_data          = '0;
        bus.response_fifo_full     = 1'b0;
        enable                     = 1'b1;

        // Reset values, with enable and a non-empty FIFO to prove no pop during reset.
        repeat (3) tick();
        check("rst read_enable", int'(bus.request_fifo_read_enable), 0);
        check("rst up_valid", int'(bus.up_request_valid), 0);
        check("rst up_line", int'(bus.up_request_line), 0);
        check("rst up_chunk", int'(bus.up_request_chunk), 0);
        check("rst up_pixels", int'(bus.up_request_pixels), 0);
        check("rst write_enable", int'(bus.response_fifo_write_enable), 0);
        check("rst pixel_ready", int'(bus.pixel_in_ready), 1);
        check("rst busy", int'(busy), 0);
        check("rst errors", int'({timeout_error, overflow_error, bad_request_error}), 0);

        bus.request_fifo_empty = 1'b1;
        bus.up_request_ready   = 1'b1;
        reset_n                = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            h_active = vecs[i].h_active;
            run_request(vecs[i].line, vecs[i].chunk, vecs[i].valid, vecs[i].pixels,
                        $sformatf("vec%0d", i));
        end

        // Full 640-pixel line, chunks 0..19.
        h_active = 11'd640;
        wr0 = wr_count;
        hs0 = hs_count;
        for (int c = 0; c < 20; c++) begin
            run_request(11'd5, 6'(c), 1'b1, 32, $sformatf("line640 c%0d", c));
        end
        check("line640 total writes", wr_count - wr0, 640);
        check("line640 handshakes", hs_count - hs0, 20);
        check("line640 errors", int'({timeout_error, overflow_error, bad_request_error}), 0);

        // Request held while upstream not ready and enable dropped; then backpressure mid-chunk.
        bus.up_request_ready = 1'b0;
        wr0 = wr_count;
        push_req(11'd9, 6'd3, ok);
        check("hold pop", int'(ok), 1);
        enable = 1'b0;
        repeat (6) tick();
        check("hold valid", int'(bus.up_request_valid), 1);
        check("hold line", int'(bus.up_request_line), 9);
        check("hold chunk", int'(bus.up_request_chunk), 3);
        check("hold pixels", int'(bus.up_request_pixels), 32);
        bus.up_request_ready = 1'b1;
        wait_hs(ok);
        check("hold handshake", int'(ok), 1);
        h_active = 11'd100;
        send_pixels(10, got);
        bus.response_fifo_full = 1'b1;
        bus.pixel_in_valid     = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            check($sformatf("stall ready c%0d", i), int'(bus.pixel_in_ready), 0);
            tick();
        end
        bus.pixel_in_valid     = 1'b0;
        bus.response_fifo_full = 1'b0;
        check("stall writes", wr_count - wr0, 10);
        check("stall busy", int'(busy), 1);
        send_pixels(22, got);
        tick();
        check("stall total writes", wr_count - wr0, 32);
        check("stall idle", int'(busy), 0);
        check("stall errors", int'({timeout_error, overflow_error, bad_request_error}), 0);
        bus.request_fifo_empty = 1'b0;
        tick();
        check("disabled no pop", int'(bus.request_fifo_read_enable), 0);
        bus.request_fifo_empty = 1'b1;
        enable   = 1'b1;
        h_active = 11'd640;

        // Upstream stalls after 31 of 32 pixels.
        wr0 = wr_count;
        push_req(11'd11, 6'd0, ok);
        wait_hs(ok);
        check("wdog handshake", int'(ok), 1);
        send_pixels(31, got);
        repeat (1022) tick();
        check("wdog not yet", int'(timeout_error), 0);
        check("wdog still busy", int'(busy), 1);
        tick();
        check("wdog timeout", int'(timeout_error), 1);
        check("wdog idle", int'(busy), 0);
        check("wdog writes", wr_count - wr0, 31);
        pulse_clear();
        check("wdog cleared", int'(timeout_error), 0);
        run_request(11'd11, 6'd1, 1'b1, 32, "after wdog");

        // Stray pixel while idle, then clear, then clear colliding with a new event.
        wr0 = wr_count;
        bus.pixel_in_valid = 1'b1;
        bus.pixel_in_data  = 16'hBEEF;
        @(negedge clock);
        check("idle pixel_ready", int'(bus.pixel_in_ready), 1);
        check("idle write_enable", int'(bus.response_fifo_write_enable), 0);
        tick();
        bus.pixel_in_valid = 1'b0;
        check("overflow set", int'(overflow_error), 1);
        check("overflow no write", wr_count - wr0, 0);
        pulse_clear();
        check("overflow cleared", int'(overflow_error), 0);
        bus.pixel_in_valid = 1'b1;
        tick();
        clear_errors = 1'b1;
        tick();
        check("clear vs event", int'(overflow_error), 1);
        bus.pixel_in_valid = 1'b0;
        tick();
        clear_errors = 1'b0;
        check("clear after event", int'(overflow_error), 0);

        // Reset asserted for one cycle mid-stream.
        push_req(11'd12, 6'd2, ok);
        wait_hs(ok);
        check("rstmid handshake", int'(ok), 1);
        send_pixels(5, got);
        wr0 = wr_count;
        bus.pixel_in_valid = 1'b1;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rstmid busy", int'(busy), 0);
        check("rstmid up_valid", int'(bus.up_request_valid), 0);
        check("rstmid up_fields", int'({bus.up_request_line, bus.up_request_chunk,
                                         bus.up_request_pixels}), 0);
        check("rstmid errors", int'({timeout_error, overflow_error, bad_request_error}), 0);
        check("rstmid pixel_ready", int'(bus.pixel_in_ready), 1);
        check("rstmid write_enable", int'(bus.response_fifo_write_enable), 0);
        repeat (3) tick();
        bus.pixel_in_valid = 1'b0;
        tick();
        check("rstmid no writes", wr_count - wr0, 0);
        pulse_clear();
        run_request(11'd12, 6'd3, 1'b1, 32, "after rstmid");

        check("write data passthrough", data_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/video_request_scheduler.md
VIDEO_REQUEST_SCHEDULER -- requirements
Module: VideoRequestScheduler
Interface
REQ-001 SHALL have parameters: CHUNK_BITS, default 5, log2 pixels per chunk; TIMEOUT_BITS, default 10, watchdog width (limit 2^TIMEOUT_BITS-1 cycles).
REQ-002 SHALL use one clock and a synchronous, active-low reset: clock  in  1  scaler clock, sole clock; resetN  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: enable  in  1  accept new requests; hActive  in  11  active pixels per line; clearErrors  in  1  clear sticky errors.
REQ-004 SHALL have ports: requestFifoEmpty  in  1; requestFifoReadEnable  out  1; requestFifoReadData  in  17  {line[10:0], chunk[5:0]}.
REQ-005 SHALL have ports: upRequestValid  out  1; upRequestReady  in  1; upRequestLine  out  11; upRequestChunk  out  6; upRequestPixels  out  6  pixel count 1..32.
REQ-006 SHALL have ports: pixelInValid  in  1; pixelInReady  out  1; pixelInData  in  16  RGB565.
REQ-007 SHALL have ports: responseFifoFull  in  1; responseFifoWriteEnable  out  1; responseFifoWriteData  out  16.
REQ-008 SHALL have ports: busy  out  1; timeoutError, overflowError, badRequestError  out  1 each, sticky.
Function
REQ-009 SHALL implement FSM IDLE, POP, DECODE, ISSUE, STREAM; one request outstanding at a time.
REQ-010 IDLE: if enable && !requestFifoEmpty, assert requestFifoReadEnable for exactly one cycle, go POP.
REQ-011 POP: requestFifoReadData valid this cycle (FIFO read latency 1); capture line/chunk, go DECODE.
REQ-012 DECODE: full = hActive>>CHUNK_BITS, rem = hActive[CHUNK_BITS-1:0]; chunk<full -> count 2^CHUNK_BITS; chunk==full && rem!=0 -> count rem; else set badRequestError, drop, go IDLE.
REQ-013 DECODE with valid count SHALL go ISSUE.
REQ-014 ISSUE: upRequestValid=1 with line/chunk/count held stable until upRequestReady=1; transfer cycle moves to STREAM.
REQ-015 upRequestValid SHALL never deassert before handshake, regardless of enable.
REQ-016 STREAM: pixelInReady = !responseFifoFull; responseFifoWriteEnable = pixelInValid && pixelInReady (combinational, zero latency); responseFifoWriteData = pixelInData.
REQ-017 Remaining counter SHALL load count at ISSUE handshake, decrement per accepted pixel; last pixel accepted -> IDLE next cycle.
REQ-018 Watchdog SHALL reset on each accepted pixel and on STREAM entry; on reaching limit set timeoutError, abandon chunk, go IDLE.
REQ-019 Outside STREAM pixelInReady SHALL be 1, pixels discarded (no FIFO write), overflowError set on any pixelInValid.
REQ-020 A pixel arriving while responseFifoFull SHALL stall (not drop, not count); watchdog keeps counting.
REQ-021 Once in ISSUE or STREAM, enable=0 SHALL NOT abort; block returns to IDLE and stops popping.
REQ-022 busy SHALL be 1 in any state other than IDLE.
REQ-023 clearErrors SHALL clear all sticky errors next cycle; a simultaneous new error event SHALL win (flag stays 1).
REQ-024 hActive SHALL be sampled at DECODE only; changes mid-chunk do not affect count.
Reset
REQ-025 resetN=0 at a clock edge SHALL force IDLE, clear counters, watchdog, captured request and all error flags.
REQ-026 Reset values: requestFifoReadEnable=0, upRequestValid=0, upRequest* fields=0, responseFifoWriteEnable=0, busy=0, errors=0; pixelInReady=1 (IDLE drain).
REQ-027 Reset mid-STREAM SHALL abandon chunk with no further FIFO writes.
Structure
REQ-028 Shared package SHALL hold HACTIVE_BITS=11, VACTIVE_BITS=11, CHUNKNUM_BITS, REQUEST_BITS, BITS_PER_PIXEL=16 and the FSM state encoding.
REQ-029 One sub-module, ChunkSizeDecoder (chunk, hActive, CHUNK_BITS -> count, invalid), is natural; the remainder stays inline.
Verification
REQ-030 hActive=640, requests line 5 chunks 0..19, ready always, 32 pixels each -> 20 handshakes upRequestPixels=32, 640 FIFO writes, no errors.
REQ-031 hActive=650, request chunk 20 -> upRequestPixels=10, IDLE after 10th pixel; chunk 21 -> badRequestError=1, no upstream request.
REQ-032 responseFifoFull=1 for 8 cycles mid-chunk -> pixelInReady=0, no writes, count unchanged, completes with exactly 32 writes.
REQ-033 Upstream delivers 31 of 32 pixels then stops -> timeoutError=1 after 1023 cycles, state IDLE, next request processed.
REQ-034 pixelInValid=1 while IDLE -> overflowError=1, no FIFO write; clearErrors pulse -> 0 next cycle.
REQ-035 resetN=0 for one cycle mid-STREAM -> all outputs at reset values next cycle, no writes thereafter until new request.
